// File: rtl/ssd_pkg.sv
// Shared types and defaults for the SSD serial link (frame transmitter and future destuffer).
// The PAR state exists only when SSD_TX_PARITY_EN is defined.
package ssd_pkg;

  localparam int SSD_DATA_W  = 8;
  localparam int SSD_PRE_LEN = 5;

  // Counter width helper that never returns zero, so 1-value counters still get a bit.
  function automatic int ssd_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int SSD_RUN_W     = ssd_cnt_w(SSD_PRE_LEN);
  localparam int SSD_PRE_CNT_W = ssd_cnt_w(SSD_PRE_LEN + 1);
  localparam int SSD_BIT_CNT_W = ssd_cnt_w(SSD_DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DELIM,
    DATA,
    STUFF
`ifdef SSD_TX_PARITY_EN
    , PAR
`endif
  } ssd_state_e;

endpackage

// File: rtl/ssd_stuff_ctr.sv
// Consecutive-ones run counter with stuff request; shared by the transmitter and the
// receiver-side destuffer. The count includes the bit presented on the same clock edge.
module ssd_stuff_ctr
  import ssd_pkg::*;
#(
  parameter int PRE_LEN = SSD_PRE_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic stuff_req,
  output logic near_full
);

  localparam int RUN_W = ssd_cnt_w(PRE_LEN);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(PRE_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_NEAR = RUN_W'(PRE_LEN - 2);

  logic [RUN_W-1:0] run_reg;
  logic [RUN_W-1:0] run_next;

  always_comb begin
    run_next = run_reg;
    if (clr) begin
      run_next = '0;
    end else if (en) begin
      run_next = bit_in ? run_reg + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg <= '0;
    end else begin
      run_reg <= run_next;
    end
  end

  // stuff_req: the bit now on the line completed a run; near_full: a further 1 would.
  assign stuff_req = (run_reg == RUN_FULL);
  assign near_full = (run_reg == RUN_NEAR);

endmodule

// File: rtl/ssd_frame_tx.sv
// SSD frame transmitter: preamble of ones, 0 delimiter, bit-stuffed MSB-first payload.
// Define SSD_TX_PARITY_EN to append a stuffed even-parity bit after the payload.
module ssd_frame_tx
  import ssd_pkg::*;
#(
  parameter int DATA_W  = SSD_DATA_W,
  parameter int PRE_LEN = SSD_PRE_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              serout,
  output logic              detect,
  output logic              busy,
  output logic              frame_done
);

  localparam int PRE_CNT_W = ssd_cnt_w(PRE_LEN + 1);
  localparam int BIT_CNT_W = ssd_cnt_w(DATA_W + 1);
  localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRE_LEN);
  localparam logic [BIT_CNT_W-1:0] BIT_END  = BIT_CNT_W'(DATA_W);
`ifndef SSD_TX_PARITY_EN
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);
`endif

  ssd_state_e             state_reg, state_next;
  logic [PRE_CNT_W-1:0]   pre_cnt_reg, pre_cnt_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]      shift_reg, shift_next;
  logic                   serout_reg, serout_next;
  logic                   frame_done_reg, frame_done_next;
  logic                   busy_reg;
  logic                   in_ready_reg;
`ifdef SSD_TX_PARITY_EN
  logic                   parity_reg, parity_next;
  logic                   emit_par;
`endif

  logic emit_data;
  logic emit_stuff;
  logic run_clr;
  logic run_en;
  logic run_bit;
  logic stuff_req;
  logic near_full;

  ssd_stuff_ctr #(
    .PRE_LEN (PRE_LEN)
  ) u_stuff_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (run_clr),
    .en        (run_en),
    .bit_in    (run_bit),
    .stuff_req (stuff_req),
    .near_full (near_full)
  );

  // Outputs are registered, so every decision here selects the bit for the next cycle.
  always_comb begin
    state_next      = state_reg;
    pre_cnt_next    = pre_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    serout_next     = 1'b0;
    frame_done_next = 1'b0;
    run_clr         = 1'b0;
    run_en          = 1'b0;
    run_bit         = 1'b0;
    emit_data       = 1'b0;
    emit_stuff      = 1'b0;
`ifdef SSD_TX_PARITY_EN
    parity_next     = parity_reg;
    emit_par        = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next   = PRE;
          serout_next  = 1'b1;
          pre_cnt_next = PRE_CNT_W'(1);
          bit_cnt_next = '0;
          shift_next   = in_data;
          run_clr      = 1'b1;
`ifdef SSD_TX_PARITY_EN
          parity_next  = ^in_data;
`endif
        end
      end
      PRE: begin
        if (pre_cnt_reg == PRE_LAST) begin
          state_next = DELIM;
          run_clr    = 1'b1;
        end else begin
          serout_next  = 1'b1;
          pre_cnt_next = pre_cnt_reg + 1'b1;
        end
      end
      DELIM: emit_data = 1'b1;
      DATA: begin
        if (frame_done_reg) begin
          state_next = IDLE;
        end else if (stuff_req) begin
          emit_stuff = 1'b1;
`ifdef SSD_TX_PARITY_EN
        end else if (bit_cnt_reg == BIT_END) begin
          emit_par = 1'b1;
`endif
        end else begin
          emit_data = 1'b1;
        end
      end
      STUFF: begin
        if (frame_done_reg) begin
          state_next = IDLE;
`ifdef SSD_TX_PARITY_EN
        end else if (bit_cnt_reg == BIT_END) begin
          emit_par = 1'b1;
`endif
        end else begin
          emit_data = 1'b1;
        end
      end
`ifdef SSD_TX_PARITY_EN
      PAR: begin
        if (frame_done_reg) begin
          state_next = IDLE;
        end else begin
          emit_stuff = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    if (emit_data) begin
      state_next   = DATA;
      serout_next  = shift_reg[DATA_W-1];
      shift_next   = shift_reg << 1;
      bit_cnt_next = bit_cnt_reg + 1'b1;
      run_en       = 1'b1;
      run_bit      = shift_reg[DATA_W-1];
`ifndef SSD_TX_PARITY_EN
      // Final payload bit ends the frame unless it completes a run and needs a stuff bit.
      frame_done_next = (bit_cnt_reg == BIT_LAST) && !(shift_reg[DATA_W-1] && near_full);
`endif
    end

    if (emit_stuff) begin
      state_next = STUFF;
      run_clr    = 1'b1;
`ifdef SSD_TX_PARITY_EN
      frame_done_next = (state_reg == PAR);
`else
      frame_done_next = (bit_cnt_reg == BIT_END);
`endif
    end

`ifdef SSD_TX_PARITY_EN
    if (emit_par) begin
      state_next      = PAR;
      serout_next     = parity_reg;
      run_en          = 1'b1;
      run_bit         = parity_reg;
      frame_done_next = !(parity_reg && near_full);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      pre_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      serout_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      in_ready_reg   <= 1'b1;
`ifdef SSD_TX_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      pre_cnt_reg    <= pre_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      serout_reg     <= serout_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= (state_next != IDLE);
      in_ready_reg   <= (state_next == IDLE);
`ifdef SSD_TX_PARITY_EN
      parity_reg     <= parity_next;
`endif
    end
  end

  assign serout     = serout_reg;
  assign detect     = busy_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign in_ready   = in_ready_reg;

endmodule
